// File: rtl/mdu_seq_if.sv
// Decoder-to-MDU bus for the miniRV RV32M sequencer.
// The master is the issue/decode side, and the slave is mdu_seq.
interface mdu_seq_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, funct3, rs1, rs2, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, funct3, rs1, rs2, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/mdu_seq.sv
// Iterative RV32M unit: 32-step shift-add multiply and restoring divide on operand magnitudes.
// Define MDU_DIV_EN to build the divider; otherwise divide ops complete at once with result 0.
module mdu_seq (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  mdu_seq_if.slave    bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef MDU_DIV_EN
    S_DIV  = 2'd3,
`endif
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;

  logic        in_sign_a, in_sign_b;
  logic [31:0] in_mag_a, in_mag_b;
  logic        busy;

  // rs1 is unsigned only for MULHU and the U divides; rs2 is also unsigned for MULHSU.
  assign in_sign_a = (bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11)) & bus.rs1[31];
  assign in_sign_b = (bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1]) & bus.rs2[31];
  assign in_mag_a  = in_sign_a ? (32'd0 - bus.rs1) : bus.rs1;
  assign in_mag_b  = in_sign_b ? (32'd0 - bus.rs2) : bus.rs2;

  logic [63:0] mul_addend, mul_sum, mul_fix;
  logic [31:0] mul_res;
  assign mul_addend = b_q[cnt_q[4:0]] ? ({32'd0, a_q} << cnt_q[4:0]) : 64'd0;
  assign mul_sum    = acc_q + mul_addend;
  assign mul_fix    = (sign_a_q ^ sign_b_q) ? (64'd0 - mul_sum) : mul_sum;
  assign mul_res    = (op_q == 3'b000) ? mul_fix[31:0] : mul_fix[63:32];

`ifdef MDU_DIV_EN
  // acc holds {remainder, dividend/quotient}; the shifted remainder needs 33 bits.
  logic [33:0] div_diff;
  logic        div_ok;
  logic [63:0] div_step;
  logic [31:0] quo_fix, rem_fix, div_res, rs1_orig;
  logic        div_zero, div_ovf;
  assign div_diff = {1'b0, acc_q[63:31]} - {2'b00, b_q};
  assign div_ok   = ~div_diff[33];
  assign div_step = {(div_ok ? div_diff[31:0] : acc_q[62:31]), acc_q[30:0], div_ok};
  assign quo_fix  = (sign_a_q ^ sign_b_q) ? (32'd0 - div_step[31:0]) : div_step[31:0];
  assign rem_fix  = sign_a_q ? (32'd0 - div_step[63:32]) : div_step[63:32];
  assign div_res  = op_q[1] ? rem_fix : quo_fix;
  assign rs1_orig = sign_a_q ? (32'd0 - a_q) : a_q;
  assign div_zero = (b_q == 32'd0);
  assign div_ovf  = ~op_q[0] & sign_a_q & (a_q == 32'h8000_0000) & sign_b_q & (b_q == 32'd1);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d     = bus.funct3;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          a_d      = in_mag_a;
          b_d      = in_mag_b;
          cnt_d    = 6'd0;
`ifdef MDU_DIV_EN
          acc_d    = {32'd0, (bus.funct3[2] ? in_mag_a : 32'd0)};
          state_d  = bus.funct3[2] ? S_DIV : S_MUL;
`else
          acc_d    = 64'd0;
          if (bus.funct3[2]) begin
            state_d  = S_DONE;
            result_d = 32'd0;
          end else begin
            state_d  = S_MUL;
          end
`endif
        end
      end
      S_MUL: begin
        acc_d = mul_sum;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d  = S_DONE;
          result_d = mul_res;
        end
      end
`ifdef MDU_DIV_EN
      S_DIV: begin
        if (cnt_q == 6'd0 && div_zero) begin
          state_d  = S_DONE;
          result_d = op_q[1] ? rs1_orig : 32'hFFFF_FFFF;
        end else if (cnt_q == 6'd0 && div_ovf) begin
          state_d  = S_DONE;
          result_d = op_q[1] ? 32'd0 : 32'h8000_0000;
        end else begin
          acc_d = div_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d  = S_DONE;
            result_d = div_res;
          end
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A redirect abandons the operation without touching the visible result.
    if (bus.flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      op_q     <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= 64'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

`ifdef MDU_DIV_EN
  assign busy = (state_q == S_MUL) || (state_q == S_DIV);
`else
  assign busy = (state_q == S_MUL);
`endif
  assign bus.busy   = busy;
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
  assign bus.stall  = ~cpu_rst & (((state_q == S_IDLE) & bus.start & ~bus.flush) | busy);
endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative RV32M multiply/divide sequencer for the miniRV pipeline. It sits beside the ALU in the execute stage. It accepts one M-extension operation (opcode 0110011, funct7 0000001) from the decoder and runs a 32-step shift-add multiply or restoring divide. While the operation is in progress it stalls the front of the pipeline. It returns the 32-bit result with a one-cycle done pulse.

## Interface
Parameters:
- none; the datapath width is fixed at 32 bits.

Ports:
- cpu_clk  in  1  clock. The only clock; all state changes on the rising edge.
- cpu_rst  in  1  reset. Synchronous and active-high.
- start  in  1  request. High while an M-extension instruction sits in EX.
- funct3  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  in  32  operand A.
- rs2  in  32  operand B.
- flush  in  1  cancels the operation in flight (branch or jump redirect).
- stall  out  1  freezes PC, IF/ID and ID/EX.
- busy  out  1  high when the state is MUL or DIV.
- done  out  1  one-cycle pulse; result is valid in this cycle.
- result  out  32  registered result. Holds its value until the next done.

## Operation
- States: IDLE, MUL, DIV, DONE. Encoding is free.
- IDLE:
  - With start=1 and flush=0, latch funct3.
  - Latch magnitudes of rs1/rs2 and their sign flags. A value is signed per op: MUL/MULH/DIV/REM use both signed; MULHSU uses rs1 signed, rs2 unsigned; the U ops use both unsigned.
  - Clear the 6-bit step counter.
  - Go to MUL if funct3[2]=0, else DIV.
- MUL:
  - 32 steps, one bit of |rs2| (LSB first) per step.
  - 64-bit accumulator: add |rs1|<<k when the bit is set.
  - After step 31, go to DONE.
- DIV:
  - 32 restoring steps, MSB first.
  - Shift the remainder left and try to subtract |rs2|; the quotient bit is 1 if no borrow.
  - After step 31, go to DONE.
- DIV fast paths. These take effect in the first DIV cycle, then go to DONE:
  - rs2=0: DIV/DIVU give 32'hFFFF_FFFF; REM/REMU give rs1.
  - DIV/REM with rs1=32'h8000_0000 and rs2=32'hFFFF_FFFF: quotient 32'h8000_0000, remainder 0.
- Sign fix in DONE entry:
  - Product is negated if signA^signB.
  - Quotient is negated if signA^signB.
  - Remainder takes the sign of rs1.
- result selection:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE: done=1, stall=0, result valid. Always returns to IDLE the next cycle.
- stall = (state==IDLE & start & ~flush) | busy.
  - stall is low in DONE, so the instruction retires and start then reflects the next instruction.
- Priority: cpu_rst > flush > normal.
  - flush in any state forces IDLE on the next edge.
  - A flushed operation produces no done pulse and leaves result unchanged.
- Reset: state IDLE, counter 0, result 0, done 0, busy 0. stall is 0 while cpu_rst=1, regardless of start.

## Timing
- The start cycle is T0.
- Full-length operation:
  - busy is high T1–T32.
  - stall is high T0–T32.
  - done and result are valid at T33.
  - Latency is 33 cycles; initiation interval is 34 cycles. A new start is accepted at T34 at the earliest, in IDLE.
- Divide fast path: DIV is entered at T1, DONE at T2 (latency 2).
- start asserted during DONE is ignored. The decoder re-presents it the next cycle.
- Operands are captured only at T0. rs1/rs2 changes afterwards have no effect.
- Reset asserted mid-operation: all outputs are at reset values in the cycle after the edge.

## Configuration
- MDU_DIV_EN defined:
  - Full divider as above.
- MDU_DIV_EN undefined:
  - No DIV state or divide datapath is generated.
  - A start with funct3[2]=1 goes directly to DONE at T1, with result=0 and stall high only in T0.
  - Multiply behaviour is unchanged.

## Test plan
- MUL, rs1=7, rs2=-3 (32'hFFFF_FFFD) → done at T33, result=32'hFFFF_FFEB; stall high for exactly 33 cycles.
- MULHU, rs1=rs2=32'hFFFF_FFFF → result=32'hFFFF_FFFE. MULH with the same operands → result=0.
- DIV, rs1=-7, rs2=2 → result=32'hFFFF_FFFD. REM with the same operands → result=32'hFFFF_FFFF (-1).
- DIVU, rs1=5, rs2=0 → done at T2, result=32'hFFFF_FFFF. REM, rs1=32'h8000_0000, rs2=-1 → result=0.
- flush at T10 of a MUL → IDLE at T11, no done pulse, result keeps its old value, stall low at T11.
- cpu_rst at T5 of a DIV → busy=stall=done=0 and result=0 next cycle. Without MDU_DIV_EN, DIV → done at T1 with result=0.
